clock_div_prog: RTL
===================

# clock_div_prog

Programmable multi-channel clock divider, the parametrised successor to the single fixed-ratio `Clock_Div`. It generates `NUM_CH` independent divided clocks from one `clk_in`, each with a divide ratio programmable at run time over a valid/ready config port. Ratio changes are glitch-free: they take effect only at a period boundary. Outputs feed test-chip shift-register and readout timing as registered fabric signals, not as global clock buffers.

## Interface
- `COUNT_WIDTH`, 8: width of the divide-ratio and counter fields.
- `NUM_CH`, 2: number of output channels, 1..8.
- `DEFAULT_DIV`, 4: ratio loaded into every channel on reset; must satisfy 2 ≤ `DEFAULT_DIV` ≤ 2^`COUNT_WIDTH`−1.
- `clk_in` input, 1 bit: the single clock. All logic is on its rising edge.
- `rst` input, 1 bit: reset. Synchronous and active-high.
- `cfg_valid` input, 1 bit: a ratio update is offered.
- `cfg_ready` output, 1 bit: the update can be accepted this cycle.
- `cfg_ch` input, 3 bits: target channel index.
- `cfg_div` input, `COUNT_WIDTH` bits: new ratio R.
- `en` input, `NUM_CH` bits: per-channel run enable. Present only with `CLKDIV_GATE_EN`.
- `clk_out` output, `NUM_CH` bits: divided clocks, registered.
- `rise_stb` output, `NUM_CH` bits: one-cycle strobe, high in the first cycle of each `clk_out` high phase.
- `pend` output, `NUM_CH` bits: the channel holds an unapplied ratio.

## Operation
- Per channel registers: `cnt` (`COUNT_WIDTH` bits), `div_cur`, `div_pend`, `pend`.
- Ratio clamp: a written R of 0 or 1 is stored as 2.
- High length H = ceil(R/2). Low length = R − H.
- Each enabled, running edge:
  - `clk_out` <= (`cnt` < H).
  - `rise_stb` <= (`cnt` == 0).
  - `cnt` <= (`cnt` == R−1) ? 0 : `cnt`+1.
- Period boundary is the edge at which `cnt` == R−1. At that edge, if `pend` is set, then `div_cur` <= `div_pend` and `pend` is cleared. The new ratio governs the period starting at `cnt` = 0.
- Config handshake:
  - Transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` is `!pend[cfg_ch]`, decoded combinationally from `cfg_ch`.
  - If `cfg_ch` ≥ `NUM_CH`, `cfg_ready` = 1 and the write is discarded.
- Write and boundary on the same channel in the same cycle: the boundary applies the old `div_pend` state (if any). The new value becomes pending and is applied at the next boundary.
- Channels are fully independent. There is no phase alignment between channels after a ratio change.

## Timing
- During reset and on the edge after it:
  - `clk_out` = 0, `rise_stb` = 0, `pend` = 0.
  - `cnt` = 0, `div_cur` = `DEFAULT_DIV`.
  - `cfg_ready` = 1.
- First edge with `rst` = 0: `clk_out` and `rise_stb` go to 1. The output period is exactly R `clk_in` cycles.
- Update latency: the new ratio is applied between 1 and R_old cycles after acceptance, always at a boundary. No output runt pulse ever occurs.
- `rst` asserted mid-period: the next edge restores the reset state unconditionally, and any pending update is dropped.

## Configuration
- `CLKDIV_GATE_EN` defined:
  - The `en` port exists.
  - When `en[i]` falls, channel i completes its current period through the boundary, then parks with `cnt` = 0 and `clk_out` = 0.
  - While parked, a pending ratio is applied on the next edge.
  - When `en[i]` rises, the first edge with it high drives `clk_out` = 1 and `rise_stb` = 1.
- `CLKDIV_GATE_EN` undefined: the `en` port is absent and all channels run continuously from reset.

## Structure
- Package `clock_div_pkg` holds:
  - the ratio clamp function;
  - the high-length function H = ceil(R/2);
  - the constant `CLKDIV_MIN_DIV` = 2.
- Sub-module `clock_div_ch` implements one channel: counter, registers, boundary logic and gating. It is instantiated `NUM_CH` times by a generate loop.
- The top level keeps only the config decode and the `cfg_ready` mux.

## Test plan
- Reset release with `DEFAULT_DIV` = 4: `clk_out[0]` pattern 1,1,0,0 repeating, and `rise_stb` high every 4th cycle starting at the first edge.
- Write R = 5 to ch0 mid-period: the current period completes at 4 cycles. Following periods run high 3, low 2. `pend[0]` is 1 from acceptance until that boundary.
- Write R = 0 to ch1: the channel runs at ratio 2, toggling each cycle. A second write to ch1 before the boundary sees `cfg_ready` = 0. A write with `cfg_ch` = 7 is accepted and has no effect.
- Write coincident with ch0's boundary, with no prior pending value: the ratio is unchanged for one more period, then the new ratio applies.
- `rst` pulsed for 1 cycle mid high phase while a ratio is pending: outputs return to 0 and `pend` is cleared. On the next edge the divider restarts at `DEFAULT_DIV`.
- With `CLKDIV_GATE_EN`, drop `en[0]` in the second cycle of an R = 6 period: ch0 finishes the period at 6 cycles, holds 0, and on re-enable rises on the first enabled edge.

Source files
------------

// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared constants, channel mode type and ratio helpers for the
// programmable clock divider.
//   CLKDIV_MIN_DIV : smallest ratio a channel will ever run at
//   ch_mode_e      : per-channel run/park classification
//   clkdiv_clamp() : maps a written ratio of 0 or 1 to CLKDIV_MIN_DIV
//   clkdiv_high()  : high-phase length, ceil(R/2)
package clock_div_pkg;

  localparam int unsigned CLKDIV_MIN_DIV = 2;

  typedef enum logic {
    CH_RUN  = 1'b0,
    CH_PARK = 1'b1
  } ch_mode_e;

  function automatic int unsigned clkdiv_clamp(input int unsigned r);
    return (r < CLKDIV_MIN_DIV) ? CLKDIV_MIN_DIV : r;
  endfunction

  function automatic int unsigned clkdiv_high(input int unsigned r);
    return (r + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clock_div_ch.sv
// clock_div_ch: one divider channel. Free-running period counter, current and
// pending ratio registers, period-boundary ratio swap and enable parking.
// Ports:
//   i_clk      : divider clock (rising edge)
//   i_rst      : synchronous active-high reset
//   i_en       : run enable; tie high for a free-running channel
//   i_wr       : accepted config write for this channel (already handshaken)
//   i_div      : raw written ratio (clamped here)
//   o_clk_out  : registered divided clock
//   o_rise_stb : high in the first cycle of each o_clk_out high phase
//   o_pend     : a written ratio is waiting for the next boundary
//
// state   | meaning
// CH_RUN  | counting; outputs follow the counter
// CH_PARK | disabled and at period start; outputs held low, counter held at 0
module clock_div_ch
  import clock_div_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_wr,
  input  logic [COUNT_WIDTH-1:0] i_div,
  output logic                   o_clk_out,
  output logic                   o_rise_stb,
  output logic                   o_pend
);

  localparam logic [COUNT_WIDTH-1:0] RST_DIV = COUNT_WIDTH'(DEFAULT_DIV);

  logic [COUNT_WIDTH-1:0] r_cnt, r_div_cur, r_div_pend;
  logic                   r_pend, r_clk_out, r_rise_stb;

  logic [COUNT_WIDTH-1:0] w_cnt_nxt, w_div_cur_nxt, w_div_pend_nxt;
  logic [COUNT_WIDTH-1:0] w_high, w_last;
  logic                   w_pend_nxt, w_clk_out_nxt, w_rise_nxt, w_boundary;
  ch_mode_e               w_mode;

  assign w_high     = COUNT_WIDTH'(clkdiv_high(32'(r_div_cur)));
  assign w_last     = r_div_cur - COUNT_WIDTH'(1);
  assign w_boundary = (r_cnt == w_last);

  // Dropping the enable mid-period lets the period run out; the counter only
  // returns to 0 at a boundary, so cnt == 0 marks a safe place to stop.
  assign w_mode = (!i_en && (r_cnt == '0)) ? CH_PARK : CH_RUN;

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_div_cur_nxt  = r_div_cur;
    w_div_pend_nxt = r_div_pend;
    w_pend_nxt     = r_pend;
    w_clk_out_nxt  = 1'b0;
    w_rise_nxt     = 1'b0;
    case (w_mode)
      CH_RUN: begin
        w_clk_out_nxt = (r_cnt < w_high);
        w_rise_nxt    = (r_cnt == '0);
        w_cnt_nxt     = w_boundary ? '0 : r_cnt + COUNT_WIDTH'(1);
        if (w_boundary && r_pend) begin
          w_div_cur_nxt = r_div_pend;
          w_pend_nxt    = 1'b0;
        end
      end
      CH_PARK: begin
        w_cnt_nxt = '0;
        if (r_pend) begin
          w_div_cur_nxt = r_div_pend;
          w_pend_nxt    = 1'b0;
        end
      end
      default: ;
    endcase
    // A write can only arrive while nothing is pending, so it never collides
    // with the swap above; it simply becomes pending for the next boundary.
    if (i_wr) begin
      w_div_pend_nxt = COUNT_WIDTH'(clkdiv_clamp(32'(i_div)));
      w_pend_nxt     = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_div_cur  <= RST_DIV;
      r_div_pend <= RST_DIV;
      r_pend     <= 1'b0;
      r_clk_out  <= 1'b0;
      r_rise_stb <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_div_cur  <= w_div_cur_nxt;
      r_div_pend <= w_div_pend_nxt;
      r_pend     <= w_pend_nxt;
      r_clk_out  <= w_clk_out_nxt;
      r_rise_stb <= w_rise_nxt;
    end
  end

  assign o_clk_out  = r_clk_out;
  assign o_rise_stb = r_rise_stb;
  assign o_pend     = r_pend;

endmodule

// File: rtl/clock_div_prog.sv
// clock_div_prog: programmable multi-channel clock divider. NUM_CH independent
// channels with run-time ratios loaded over a valid/ready port; ratio changes
// take effect only at period boundaries.
// Optional feature macro: CLKDIV_GATE_EN adds the per-channel i_en run enable.
// Ports:
//   i_clk_in    : the single clock (rising edge)
//   i_rst       : synchronous active-high reset
//   i_cfg_valid : ratio update offered
//   o_cfg_ready : update can be accepted (channel has nothing pending)
//   i_cfg_ch    : target channel; indices >= NUM_CH are accepted and dropped
//   i_cfg_div   : new ratio (0 and 1 run as 2)
//   i_en        : per-channel enable (CLKDIV_GATE_EN only)
//   o_clk_out   : registered divided clocks
//   o_rise_stb  : first-cycle-of-high strobes
//   o_pend      : per-channel unapplied-ratio flags
module clock_div_prog
  import clock_div_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int NUM_CH      = 2,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                   i_clk_in,
  input  logic                   i_rst,
  input  logic                   i_cfg_valid,
  output logic                   o_cfg_ready,
  input  logic [2:0]             i_cfg_ch,
  input  logic [COUNT_WIDTH-1:0] i_cfg_div,
`ifdef CLKDIV_GATE_EN
  input  logic [NUM_CH-1:0]      i_en,
`endif
  output logic [NUM_CH-1:0]      o_clk_out,
  output logic [NUM_CH-1:0]      o_rise_stb,
  output logic [NUM_CH-1:0]      o_pend
);

  logic [NUM_CH-1:0] w_en;
  logic [NUM_CH-1:0] w_wr;
  logic [7:0]        w_pend_pad;

`ifdef CLKDIV_GATE_EN
  assign w_en = i_en;
`else
  assign w_en = '1;
`endif

  // Unused channel slots read as "not pending", which makes out-of-range
  // targets always ready; their write strobe matches no channel.
  always_comb begin
    w_pend_pad = '0;
    for (int i = 0; i < NUM_CH; i++) w_pend_pad[i] = o_pend[i];
    o_cfg_ready = !w_pend_pad[i_cfg_ch];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_wr[g] = i_cfg_valid && o_cfg_ready && (i_cfg_ch == 3'(g));

    clock_div_ch #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk      (i_clk_in),
      .i_rst      (i_rst),
      .i_en       (w_en[g]),
      .i_wr       (w_wr[g]),
      .i_div      (i_cfg_div),
      .o_clk_out  (o_clk_out[g]),
      .o_rise_stb (o_rise_stb[g]),
      .o_pend     (o_pend[g])
    );
  end

endmodule
